demux_route_sequencer: RTL and testbench

- Upstream driver for the 1-to-4 demultiplexer stage.
- Accepts single data bits over a valid/ready handshake and picks the target channel, either explicit or round-robin.
- Drives the demux select, data and active-low enable with break-before-make timing.
- Each bit is presented for a programmable number of cycles, so the downstream demux never sees select change while enabled.

---
 rtl/demux_pkg.sv | 26 ++
 rtl/demux_hold_timer.sv | 33 +++
 rtl/demux_route_sequencer.sv | 160 ++++++++++++++++
 tb/tb_demux_route_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the demux route sequencer.
//   state_t  : sequencer FSM states (IDLE, SETUP, DRIVE, GAP)
//   chan_t   : 2-bit demux channel index
//   xfer_t   : captured transfer payload (channel + data bit)
//   CNT_W    : width of the hold/gap down-counter
//   NUM_CHAN : number of demux output channels
package demux_pkg;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned NUM_CHAN = 4;

  typedef logic [1:0] chan_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRIVE = 2'd2,
    GAP   = 2'd3
  } state_t;

  typedef struct packed {
    chan_t chan;
    logic  data;
  } xfer_t;

endpackage

// File: rtl/demux_hold_timer.sv
// Loadable down-counter timing each sequencer phase.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   load     in   reload the counter with load_val this edge
//   load_val in   CNT_W-bit phase length in cycles
//   done_c   out  combinational: counter sits at 1, i.e. last cycle of the phase
module demux_hold_timer
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] count;

  // Counts down to zero and parks there until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done_c = (count == CNT_W'(1));

endmodule

// File: rtl/demux_route_sequencer.sv
// Upstream driver for a 1-to-4 demux: accepts single bits over valid/ready,
// picks an explicit or round-robin channel, and drives select/data/enable
// with break-before-make timing (select settles one cycle while disabled,
// data is held HOLD_CYCLES, then GAP_CYCLES disabled before the next accept).
// Optional build macro ROUTE_COUNT_EN adds per-channel saturating route
// counters on output chan_count.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   upstream has a bit to route
//   in_data    in   bit to route
//   in_chan    in   explicit channel (auto_mode = 0)
//   auto_mode  in   1 = round-robin channel, sampled on accept only
//   in_ready   out  combinational: idle and not in reset
//   dmx_I      out  demux data
//   dmx_S      out  demux select
//   dmx_En     out  demux enable, active-low
//   busy       out  transfer in progress
//   chan_count out  (ROUTE_COUNT_EN only) four 8-bit counters, channel k at [8k+7:8k]
module demux_route_sequencer
  import demux_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_data,
  input  logic [1:0]  in_chan,
  input  logic        auto_mode,
  output logic        in_ready,
  output logic        dmx_I,
  output logic [1:0]  dmx_S,
  output logic        dmx_En,
  output logic        busy
`ifdef ROUTE_COUNT_EN
  ,
  output logic [31:0] chan_count
`endif
);

  localparam logic [CNT_W-1:0] SETUP_VAL = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_VAL  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_VAL   = CNT_W'(GAP_CYCLES);

  state_t           state, state_d;
  xfer_t            xfer, xfer_d;
  chan_t            rr_ptr, rr_d;
  logic             accept;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic             dmx_I_d;
  chan_t            dmx_S_d;
  logic             dmx_En_d;
  logic             busy_d;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  demux_hold_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done_c   (tmr_done)
  );

  // Next-state, capture and phase-timer control; outputs follow the next state.
  always_comb begin
    state_d  = state;
    xfer_d   = xfer;
    rr_d     = rr_ptr;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_d     = SETUP;
          xfer_d.data = in_data;
          xfer_d.chan = auto_mode ? rr_ptr : chan_t'(in_chan);
          // chan_t is 2 bits wide, so the increment wraps 3 -> 0.
          if (auto_mode) rr_d = rr_ptr + chan_t'(1);
          tmr_load    = 1'b1;
          tmr_val     = SETUP_VAL;
        end
      end
      SETUP: begin
        if (tmr_done) begin
          state_d  = DRIVE;
          tmr_load = 1'b1;
          tmr_val  = HOLD_VAL;
        end
      end
      DRIVE: begin
        if (tmr_done) begin
          if (GAP_CYCLES != 0) begin
            state_d  = GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_VAL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (tmr_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Captured channel only changes on accept, so select moves only into SETUP.
    dmx_S_d  = xfer_d.chan;
    dmx_En_d = (state_d != DRIVE);
    dmx_I_d  = (state_d == DRIVE) && xfer_d.data;
    busy_d   = (state_d != IDLE);
  end

  // State, capture and registered demux outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      xfer   <= '0;
      rr_ptr <= '0;
      dmx_I  <= 1'b0;
      dmx_S  <= '0;
      dmx_En <= 1'b1;
      busy   <= 1'b0;
    end else begin
      state  <= state_d;
      xfer   <= xfer_d;
      rr_ptr <= rr_d;
      dmx_I  <= dmx_I_d;
      dmx_S  <= dmx_S_d;
      dmx_En <= dmx_En_d;
      busy   <= busy_d;
    end
  end

`ifdef ROUTE_COUNT_EN
  logic [NUM_CHAN-1:0][CNT_W-1:0] cnt_q;
  logic                           drive_entry;

  assign drive_entry = (state == SETUP) && (state_d == DRIVE);

  // One saturating counter per channel, bumped as a bit starts driving.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (drive_entry && (cnt_q[xfer.chan] != '1)) begin
      cnt_q[xfer.chan] <= cnt_q[xfer.chan] + CNT_W'(1);
    end
  end

  assign chan_count = cnt_q;
`endif

endmodule

// File: tb/tb_demux_route_sequencer.sv
// Scoreboard bench for demux_route_sequencer: a transaction-level model
// predicts accepts, channels and ready/busy windows; a monitor pops the
// expected transfer each time the demux becomes enabled.
module tb_demux_route_sequencer;

  localparam int HOLD = 4;
  localparam int GAP  = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_data;
  logic [1:0] in_chan;
  logic       auto_mode;
  logic       in_ready;
  logic       dmx_I;
  logic [1:0] dmx_S;
  logic       dmx_En;
  logic       busy;
`ifdef ROUTE_COUNT_EN
  logic [31:0] chan_count;
`endif

  demux_route_sequencer #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_chan    (in_chan),
    .auto_mode  (auto_mode),
    .in_ready   (in_ready),
    .dmx_I      (dmx_I),
    .dmx_S      (dmx_S),
    .dmx_En     (dmx_En),
    .busy       (busy)
`ifdef ROUTE_COUNT_EN
    ,
    .chan_count (chan_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] chan;
    logic       data;
    int         t;
  } exp_t;

  exp_t       sbq[$];
  int         tests = 0;
  int         fails = 0;
  int         edge_n = 0;
  int         busy_end = -1;
  int         accepts = 0;
  logic [1:0] rr = 2'd0;
  int         cnt_m[4] = '{default: 0};
  bit         abort_drive = 1'b0;

  // monitor state
  logic       prev_en = 1'b1;
  logic [1:0] prev_s = 2'd0;
  logic [1:0] drv_s = 2'd0;
  int         drv_len = 0;
  exp_t       cur;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  // One clock: model reacts to the edge, then ready/busy are checked on the falling edge.
  task automatic tick();
    bit   rst_s;
    bit   ready_m;
    bit   busy_m;
    exp_t e;
    @(posedge clk);
    rst_s   = rst;
    ready_m = !rst && !(edge_n <= busy_end);
    edge_n++;
    if (rst_s) begin
      rr          = 2'd0;
      busy_end    = -1;
      sbq.delete();
      cnt_m       = '{default: 0};
      abort_drive = 1'b1;
    end else if (in_valid && ready_m) begin
      e.chan = auto_mode ? rr : in_chan;
      if (auto_mode) rr = rr + 2'd1;
      e.data = in_data;
      e.t    = edge_n;
      sbq.push_back(e);
      busy_end = edge_n + HOLD + GAP;
      accepts++;
      if (cnt_m[e.chan] < 255) cnt_m[e.chan]++;
    end
    @(negedge clk);
    busy_m = (edge_n <= busy_end);
    chk("busy", 32'(busy), 32'(busy_m));
    chk("in_ready", 32'(in_ready), 32'(!busy_m && !rst));
    if (rst_s) begin
      chk("rst_En", 32'(dmx_En), 32'(1));
      chk("rst_I", 32'(dmx_I), 32'(0));
      chk("rst_S", 32'(dmx_S), 32'(0));
    end
  endtask

  // Present one bit until the model sees it accepted (bounded).
  task automatic send(input logic am, input logic [1:0] ch, input logic d);
    int start;
    start     = accepts;
    in_valid  = 1'b1;
    auto_mode = am;
    in_chan   = ch;
    in_data   = d;
    for (int i = 0; i < 50 && accepts == start; i++) tick();
    in_valid = 1'b0;
    if (accepts == start) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: no accept within 50 cycles (edge %0d)", edge_n);
    end
  endtask

  // Monitor: each enable fall pops one expected transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (dmx_En === 1'b0 && prev_en === 1'b1) begin
        abort_drive = 1'b0;
        drv_len     = 1;
        drv_s       = dmx_S;
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_drive: enable low with empty scoreboard (edge %0d)", edge_n);
        end else begin
          cur = sbq.pop_front();
          chk("drive_chan", 32'(dmx_S), 32'(cur.chan));
          chk("setup_sel", 32'(prev_s), 32'(cur.chan));
          chk("drive_data", 32'(dmx_I), 32'(cur.data));
          chk("drive_latency", 32'(edge_n), 32'(cur.t + 1));
        end
      end else if (dmx_En === 1'b0) begin
        drv_len++;
        chk("sel_stable", 32'(dmx_S), 32'(drv_s));
        chk("data_hold", 32'(dmx_I), 32'(cur.data));
      end else begin
        if (prev_en === 1'b0 && !abort_drive) chk("hold_len", 32'(drv_len), 32'(HOLD));
        chk("idle_data", 32'(dmx_I), 32'(0));
      end
      prev_en = dmx_En;
      prev_s  = dmx_S;
    end
  end

  initial begin
    int start;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 1'b0;
    in_chan   = 2'd0;
    auto_mode = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // explicit ch2, data 1
    send(1'b0, 2'd2, 1'b1);
    repeat (10) tick();

    // round robin, valid held high for five accepts
    start     = accepts;
    auto_mode = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 100 && accepts < start + 5; i++) begin
      in_data = 1'($urandom);
      in_chan = 2'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (10) tick();

    // mode mix from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    send(1'b1, 2'd2, 1'b1);
    send(1'b0, 2'd3, 1'b0);
    send(1'b1, 2'd3, 1'b1);
    repeat (10) tick();

    // reset on the second DRIVE cycle
    send(1'b1, 2'd0, 1'b1);
    send(1'b1, 2'd0, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(1'b1, 2'd2, 1'b1);
    repeat (10) tick();

    // random traffic
    repeat (400) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 1'($urandom);
      in_chan   = 2'($urandom);
      auto_mode = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (12) tick();

`ifdef ROUTE_COUNT_EN
    for (int k = 0; k < 4; k++) chk("chan_count_rand", 32'(chan_count[8*k +: 8]), 32'(cnt_m[k]));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start     = accepts;
    auto_mode = 1'b0;
    in_chan   = 2'd1;
    in_valid  = 1'b1;
    for (int i = 0; i < 260 * 8 && accepts < start + 260; i++) begin
      in_data = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (12) tick();
    for (int k = 0; k < 4; k++) chk("chan_count_sat", 32'(chan_count[8*k +: 8]), 32'(cnt_m[k]));
`endif

    chk("scoreboard_empty", 32'(sbq.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
